// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared states, opcodes and frame helpers for the SPI master controller
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    CAPTURE,
    GAP
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int CMD_BITS   = 10;
  localparam int CNT_W      = 4;

  // Serial frame: opcode MSB sent twice, then opcode LSB, then payload MSB first
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [CMD_BITS-1:0] cmd);
    return {cmd[9], cmd[9], cmd[8], cmd[7:0]};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - command and response handshake bundle of the SPI master
interface spi_master_ctrl_if;
  import spi_master_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CMD_BITS-1:0]  cmd_data;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - TX/RX shift registers and per-state down-counter
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic                  i_shift_tx,
  input  logic                  i_shift_rx,
  input  logic                  i_miso,
  input  logic                  i_cnt_load,
  input  logic [CNT_W-1:0]      i_cnt_val,
  input  logic                  i_cnt_dec,
  output logic                  o_tx_bit,
  output logic [DATA_BITS-1:0]  o_rx_data,
  output logic                  o_done
);

  logic [FRAME_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0]  r_rx;
  logic [CNT_W-1:0]      r_cnt;

  // TX frame: parallel load on accept, shift left one bit per serial cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx <= '0;
    end else if (i_load) begin
      r_tx <= i_frame;
    end else if (i_shift_tx) begin
      r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  // RX byte: MISO enters at the LSB so the first bit ends up as the MSB
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx <= '0;
    end else if (i_shift_rx) begin
      r_rx <= {r_rx[DATA_BITS-2:0], i_miso};
    end
  end

  // Down-counter reloaded on each state entry; the FSM only decrements while not done
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_cnt_load) begin
      r_cnt <= i_cnt_val;
    end else if (i_cnt_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tx_bit  = r_tx[FRAME_BITS-1];
  assign o_rx_data = r_rx;
  assign o_done    = (r_cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI initiator turning 10-bit command words into serial frames
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  spi_master_ctrl_if.slave cmd_if,
  output logic             o_busy,
  output logic             o_ss_n,
  output logic             o_mosi,
  input  logic             i_miso
);

  // Counter reload values are "cycles in state minus one"
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] CAP_LOAD   = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e r_state;
  state_e w_next;

  logic r_ss_n;
  logic r_mosi;
  logic r_ready;
  logic r_rsp_valid;
  logic r_is_rd;

  logic                 w_load;
  logic                 w_shift_tx;
  logic                 w_shift_rx;
  logic                 w_cnt_load;
  logic [CNT_W-1:0]     w_cnt_val;
  logic                 w_cnt_dec;
  logic                 w_tx_bit;
  logic                 w_done;
  logic                 w_sel;
  logic [DATA_BITS-1:0] w_rx_data;

  spi_master_shifter u_shifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_frame    (make_frame(cmd_if.cmd_data)),
    .i_shift_tx (w_shift_tx),
    .i_shift_rx (w_shift_rx),
    .i_miso     (i_miso),
    .i_cnt_load (w_cnt_load),
    .i_cnt_val  (w_cnt_val),
    .i_cnt_dec  (w_cnt_dec),
    .o_tx_bit   (w_tx_bit),
    .o_rx_data  (w_rx_data),
    .o_done     (w_done)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus shifter/counter controls for the current cycle
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_shift_tx = 1'b0;
    w_shift_rx = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_if.cmd_valid && r_ready) begin
          w_load = 1'b1;
          w_next = START;
        end
      end
      START: begin
        // First frame bit is launched on the way out of the select cycle
        w_shift_tx = 1'b1;
        w_cnt_load = 1'b1;
        w_cnt_val  = SHIFT_LOAD;
        w_next     = SHIFT;
      end
      SHIFT: begin
        if (!w_done) begin
          w_shift_tx = 1'b1;
          w_cnt_dec  = 1'b1;
        end else if (r_is_rd) begin
          w_cnt_load = 1'b1;
          if (RD_LAT > 0) begin
            w_cnt_val = LAT_LOAD;
            w_next    = WAIT;
          end else begin
            w_cnt_val = CAP_LOAD;
            w_next    = CAPTURE;
          end
        end else begin
          w_cnt_load = 1'b1;
          w_cnt_val  = GAP_LOAD;
          w_next     = GAP;
        end
      end
      WAIT: begin
        if (!w_done) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CAP_LOAD;
          w_next     = CAPTURE;
        end
      end
      CAPTURE: begin
        w_shift_rx = 1'b1;
        if (!w_done) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_cnt_load = 1'b1;
          w_cnt_val  = GAP_LOAD;
          w_next     = GAP;
        end
      end
      GAP: begin
        if (!w_done) begin
          w_cnt_dec = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_sel = (w_next == START) || (w_next == SHIFT) || (w_next == WAIT) || (w_next == CAPTURE);

  // Pin and handshake flops follow the state being entered so they line up with it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_is_rd     <= 1'b0;
    end else begin
      r_ss_n      <= !w_sel;
      r_mosi      <= (w_next == SHIFT) && w_tx_bit;
      r_ready     <= (w_next == IDLE);
      r_rsp_valid <= (r_state == CAPTURE) && (w_next == GAP);
      if (w_load) begin
        r_is_rd <= (cmd_if.cmd_data[9:8] == OP_RD_DATA);
      end
    end
  end

  assign cmd_if.cmd_ready = r_ready;
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_data  = w_rx_data;
  assign o_busy           = (r_state != IDLE);
  assign o_ss_n           = r_ss_n;
  assign o_mosi           = r_mosi;

endmodule
